// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, fetches one word at a time
// from instruction memory, presents it (with its PC and PC+4 link value) to the
// decode/control stage, and applies branch/jump redirects that decode returns.
// Only one memory request is ever outstanding; a fetch is not pipelined.
//
// Handshakes:
//   Memory side: imem_req is held high, with imem_addr stable, until the cycle
//   in which imem_rvalid pulses; imem_rdata is captured only in that cycle.
//   Decode side: inst_valid high means inst/inst_pc are presented. The word is
//   consumed on a rising edge where inst_valid=1 and stall=0. redirect_en and
//   redirect_pc are looked at only on that consuming edge.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous active-low reset
//   stall          in   1   downstream hold; freezes the presented instruction
//   redirect_en    in   1   branch taken from control, qualified by inst_valid
//   redirect_pc    in   32  branch/jump target (bit 0 is cleared here)
//   imem_req       out  1   fetch request, held until imem_rvalid
//   imem_addr      out  32  fetch address, stable while imem_req=1
//   imem_rvalid    in   1   one-cycle response strobe
//   imem_rdata     in   32  instruction word, valid with imem_rvalid
//   inst           out  32  presented instruction; NOP_INST when not valid
//   inst_pc        out  32  PC of inst
//   inst_pc_plus4  out  32  inst_pc + 4 (link value), wraps mod 2^32
//   inst_valid     out  1   inst/inst_pc valid this cycle
//   fetch_fault    out  1   sticky misaligned-target fault
//   fetch_count    out  32  number of consumed instructions, wraps
//   state_dbg      out  2   current FSM state (0=WAIT, 1=VALID, 2=FAULT)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        inst_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] next_pc;

    // Target of the current instruction if it were consumed now. Bit 0 of a
    // redirect is dropped so JALR targets land on a halfword boundary; a
    // remaining bit 1 means the target is not word aligned.
    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect_en) begin
            next_pc = {redirect_pc[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WAIT;
            pc          <= RESET_PC;
            imem_req    <= 1'b1;
            imem_addr   <= RESET_PC;
            inst_q      <= NOP_INST;
            inst_pc     <= RESET_PC;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        inst_q     <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // While stalled nothing changes, so inst/inst_pc stay frozen
                    // and redirect_en is never looked at.
                    if (!stall) begin
                        fetch_count <= fetch_count + 32'd1;
                        inst_valid  <= 1'b0;
                        pc          <= next_pc;
                        if (next_pc[1]) begin
                            fetch_fault <= 1'b1;
                            state       <= ST_FAULT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                            state     <= ST_WAIT;
                        end
                    end
                end
                ST_FAULT: begin
                    // Terminal until reset; memory responses and redirects are ignored.
                    fetch_fault <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely in the fault state.
                    imem_req    <= 1'b0;
                    inst_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                    state       <= ST_FAULT;
                end
            endcase
        end
    end

    // Decoded from registers: the captured word is only shown while valid.
    assign inst          = inst_valid ? inst_q : NOP_INST;
    assign inst_pc_plus4 = inst_pc + 32'd4;
    assign state_dbg     = state;

endmodule
